// File: rtl/automaton_pkg.sv
// Shared types and widths for the automaton sequencer.
// The optional button debouncer is enabled with AUTOMATON_BTN_DEBOUNCE_EN.

package automaton_pkg;

  // Width of the seed pattern bus.
  localparam int PATTERN_W = 8;

  // Width of the completed-generation counter.
  localparam int COUNT_W = 8;

  // Width of the externally visible state code.
  localparam int STATE_OUT_W = 4;

  // Width of the generation-tick divider.
  // It is wide enough for the largest supported divide ratio of 2^16.
  localparam int TICK_W = 16;

  // Width of the debounce run-length counter.
  // It is wide enough for stability windows of up to 255 cycles.
  localparam int DEBOUNCE_W = 8;

  // Sequencer states.
  // The codes are visible on actual_state, so they are fixed explicitly.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_STEP  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Zero-extend a state to the width of the external state code.
  function automatic logic [STATE_OUT_W-1:0] state_code(input state_t s);
    return STATE_OUT_W'(s);
  endfunction

endpackage

// File: rtl/automaton_sequencer_btn_conditioner.sv
// Button conditioning for the start/pause button.
// The raw button is asynchronous, so it first passes through a two-flop
// synchronizer. When AUTOMATON_BTN_DEBOUNCE_EN is defined, the synchronized
// level is accepted only after DEBOUNCE_CYC consecutive samples that differ
// from the accepted level. A registered rising-edge detector then produces a
// one-cycle press pulse.

import automaton_pkg::*;

module btn_conditioner #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic filtered;
  logic prev_q;
  logic press_q;

  // Two-flop synchronizer for the asynchronous button input.
  // NOTE: Registers are updated with non-blocking assignments. Every flop then
  // samples its pre-edge inputs, so the chain shifts by one stage per clock
  // instead of collapsing into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef AUTOMATON_BTN_DEBOUNCE_EN
  localparam logic [DEBOUNCE_W-1:0] DB_LAST = DEBOUNCE_W'(DEBOUNCE_CYC - 1);

  logic                  stable_q;
  logic [DEBOUNCE_W-1:0] db_cnt_q;

  // Accept a new level only after a full run of samples that disagree with
  // the current one. Any agreeing sample restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      db_cnt_q <= '0;
    end else if (sync2_q == stable_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_LAST) begin
      stable_q <= sync2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign filtered = stable_q;
`else
  assign filtered = sync2_q;
`endif

  // Registered rising-edge detector.
  // It produces exactly one pulse per accepted press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      prev_q  <= filtered;
      press_q <= filtered & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/automaton_sequencer.sv
// Control sequencer for a cellular-automaton datapath.
// - A press in IDLE latches the seed and asks the datapath to load it.
// - Generations are then requested, either automatically every TICK_DIV
//   cycles (sw_sel=0) or once per press (sw_sel=1), until MAX_GEN
//   generations have completed.
// - In continuous mode, a press pauses the run and a second press resumes it.
// The optional button debouncer is enabled with AUTOMATON_BTN_DEBOUNCE_EN.
// Without it, DEBOUNCE_CYC has no effect.

import automaton_pkg::*;

module automaton_sequencer #(
  parameter int TICK_DIV     = 25,
  parameter int MAX_GEN      = 100,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_inicio,
  input  logic                   sw_sel,
  input  logic [PATTERN_W-1:0]   sw_bit_inicial,
  input  logic                   step_ack,
  output logic                   load_req,
  output logic [PATTERN_W-1:0]   seed,
  output logic                   step_req,
  output logic [COUNT_W-1:0]     display_instancias,
  output logic [STATE_OUT_W-1:0] actual_state
);

  // Reject parameter values that the counters cannot represent.
  if (TICK_DIV < 2 || TICK_DIV > 65536) begin : g_bad_tick_div
    $error("automaton_sequencer: TICK_DIV out of range 2..65536");
  end
  if (MAX_GEN < 1 || MAX_GEN > 255) begin : g_bad_max_gen
    $error("automaton_sequencer: MAX_GEN out of range 1..255");
  end
  if (DEBOUNCE_CYC < 2 || DEBOUNCE_CYC > 255) begin : g_bad_debounce
    $error("automaton_sequencer: DEBOUNCE_CYC out of range 2..255");
  end

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [COUNT_W-1:0] GEN_LAST  = COUNT_W'(MAX_GEN);

  logic                 press;
  state_t               state_q,  state_d;
  logic [TICK_W-1:0]    tick_q,   tick_d;
  logic [COUNT_W-1:0]   count_q,  count_d;
  logic [PATTERN_W-1:0] seed_q,   seed_d;

  btn_conditioner #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_btn (
    .clk     (clk),
    .rst_n   (rst),
    .btn_i   (btn_inicio),
    .press_o (press)
  );

  // State, tick divider, generation count and seed registers.
  // Reset clears all of them, so a STEP abandoned by reset is never resumed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      count_q <= '0;
      seed_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      count_q <= count_d;
      seed_q  <= seed_d;
    end
  end

  // Next-state logic. A press in WAIT takes priority over the terminal tick.
  // NOTE: Every _d signal is first given its hold value. This keeps paths that
  // do not assign a signal from inferring a latch.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    count_d = count_q;
    seed_d  = seed_q;

    unique case (state_q)
      S_IDLE: begin
        if (press) begin
          seed_d  = sw_bit_inicial;
          count_d = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        tick_d  = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (press) begin
          state_d = sw_sel ? S_STEP : S_PAUSE;
        end else if (sw_sel) begin
          tick_d = '0;
        end else if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          state_d = S_STEP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      S_STEP: begin
        if (step_ack) begin
          count_d = count_q + 1'b1;
          tick_d  = '0;
          state_d = (count_q + 1'b1 == GEN_LAST) ? S_DONE : S_WAIT;
        end
      end

      S_PAUSE: begin
        if (press) begin
          tick_d  = '0;
          state_d = S_WAIT;
        end
      end

      S_DONE: begin
        if (press) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state.
  // They therefore follow the asynchronous reset immediately.
  assign load_req           = (state_q == S_LOAD);
  assign step_req           = (state_q == S_STEP);
  assign seed               = seed_q;
  assign display_instancias = count_q;
  assign actual_state       = state_code(state_q);

endmodule

// File: tb/tb_automaton_sequencer.sv
// Self-checking bench for automaton_sequencer.
// A generation-level reference model predicts every output on every cycle.
// Directed scenarios then pin the key observable behaviours with literal
// expectations. AUTOMATON_BTN_DEBOUNCE_EN adds the debounce scenarios.

module tb_automaton_sequencer;

  localparam int TD = 4;
  localparam int MG = 3;
  localparam int DB = 16;
`ifdef AUTOMATON_BTN_DEBOUNCE_EN
  localparam int LAT  = 3 + DB;
  localparam int HOLD = DB + 4;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 4;
`endif
  localparam int RAW_DEPTH = DB + 3;

  localparam int P_IDLE = 0, P_LOAD = 1, P_WAIT = 2, P_STEP = 3, P_PAUSE = 4, P_DONE = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_inicio = 1'b0;
  logic       sw_sel = 1'b0;
  logic [7:0] sw_bit_inicial = 8'h00;
  logic       step_ack = 1'b0;
  logic       load_req;
  logic [7:0] seed;
  logic       step_req;
  logic [7:0] display_instancias;
  logic [3:0] actual_state;

  automaton_sequencer #(
    .TICK_DIV     (TD),
    .MAX_GEN      (MG),
    .DEBOUNCE_CYC (DB)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .btn_inicio         (btn_inicio),
    .sw_sel             (sw_sel),
    .sw_bit_inicial     (sw_bit_inicial),
    .step_ack           (step_ack),
    .load_req           (load_req),
    .seed               (seed),
    .step_req           (step_req),
    .display_instancias (display_instancias),
    .actual_state       (actual_state)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       rawq[$];
  logic       st_hist[$];
  logic       m_stable;
  logic       m_press;
  logic       m_flip;
  int         m_phase;
  int         m_gen;
  int         m_wc;
  logic [7:0] m_seed;

  task automatic model_reset();
    rawq.delete();
    st_hist.delete();
    for (int i = 0; i < RAW_DEPTH; i++) rawq.push_back(1'b0);
    for (int i = 0; i < 4; i++) st_hist.push_back(1'b0);
    m_stable = 1'b0;
    m_phase  = P_IDLE;
    m_gen    = 0;
    m_wc     = 0;
    m_seed   = 8'h00;
  endtask

  task automatic model_step();
    rawq.push_front(btn_inicio);
    void'(rawq.pop_back());
`ifdef AUTOMATON_BTN_DEBOUNCE_EN
    m_flip = 1'b1;
    for (int i = 1; i <= DB; i++) if (rawq[i+1] == m_stable) m_flip = 1'b0;
    if (m_flip) m_stable = ~m_stable;
`else
    m_flip   = 1'b0;
    m_stable = rawq[1];
`endif
    st_hist.push_front(m_stable);
    void'(st_hist.pop_back());
    m_press = st_hist[2] & ~st_hist[3];
    case (m_phase)
      P_IDLE:  if (m_press) begin m_seed = sw_bit_inicial; m_gen = 0; m_phase = P_LOAD; end
      P_LOAD:  begin m_phase = P_WAIT; m_wc = 0; end
      P_WAIT: begin
        if (m_press) m_phase = sw_sel ? P_STEP : P_PAUSE;
        else if (sw_sel) m_wc = 0;
        else begin
          m_wc++;
          if (m_wc == TD) m_phase = P_STEP;
        end
      end
      P_STEP: if (step_ack) begin
        m_gen++;
        m_wc = 0;
        m_phase = (m_gen == MG) ? P_DONE : P_WAIT;
      end
      P_PAUSE: if (m_press) begin m_phase = P_WAIT; m_wc = 0; end
      P_DONE:  if (m_press) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Compare every output against the model on each falling edge.
  initial forever begin
    @(negedge clk);
    check("state",    32'(actual_state),       32'(m_phase));
    check("load_req", 32'(load_req),           32'(m_phase == P_LOAD));
    check("step_req", 32'(step_req),           32'(m_phase == P_STEP));
    check("count",    32'(display_instancias), 32'(m_gen));
    check("seed",     32'(seed),               32'(m_seed));
  end

  // ---------------- datapath responder ----------------
  bit ack_en    = 1'b0;
  bit force_ack = 1'b0;
  int ack_delay = 2;
  int req_age   = 0;

  initial forever begin
    @(negedge clk);
    if (ack_en && step_req) begin
      req_age++;
      step_ack = (req_age == ack_delay);
    end else begin
      req_age  = 0;
      step_ack = ack_en ? 1'b0 : force_ack;
    end
  end

  // ---------------- activity monitor ----------------
  int         n_steps = 0;
  int         n_loads = 0;
  logic       prev_sr = 1'b0;
  logic [7:0] prev_disp = 8'h00;
  logic [7:0] disp_seq[$];

  initial forever begin
    @(negedge clk);
    if (step_req && !prev_sr) n_steps++;
    prev_sr = step_req;
    if (load_req) n_loads++;
    if (display_instancias != prev_disp) begin
      if (display_instancias != 8'h00) disp_seq.push_back(display_instancias);
      prev_disp = display_instancias;
    end
  end

  // ---------------- helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn();
    @(negedge clk);
    btn_inicio = 1'b1;
    cycles(HOLD);
    btn_inicio = 1'b0;
    cycles(LAT + 2);
  endtask

  task automatic wait_state(input string name, input logic [3:0] s, input int budget);
    int i = 0;
    while (actual_state !== s && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(actual_state), 32'(s));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  int loads0, steps0, n;

  initial begin
    #1 rst = 1'b0;
    cycles(3);
    check("rst_state", 32'(actual_state),       32'd0);
    check("rst_count", 32'(display_instancias), 32'd0);
    check("rst_seed",  32'(seed),               32'd0);
    check("rst_step",  32'(step_req),           32'd0);
    check("rst_load",  32'(load_req),           32'd0);
    rst = 1'b1;
    cycles(2);

    // Continuous run to DONE.
    sw_sel = 1'b0; sw_bit_inicial = 8'hA5; ack_en = 1'b1; ack_delay = 2;
    loads0 = n_loads; steps0 = n_steps;
    press_btn();
    wait_state("run_done", 4'd5, 300);
    check("run_seed",   32'(seed),               32'hA5);
    check("run_count",  32'(display_instancias), 32'd3);
    check("run_loads",  32'(n_loads - loads0),   32'd1);
    check("run_steps",  32'(n_steps - steps0),   32'd3);
    check("run_seqlen", 32'(disp_seq.size()),    32'd3);
    for (int i = 0; i < disp_seq.size() && i < 3; i++)
      check("run_seq", 32'(disp_seq[i]), 32'(i + 1));
    sw_bit_inicial = 8'h00;
    cycles(20);
    check("done_hold", 32'(display_instancias), 32'd3);
    press_btn();
    wait_state("done_to_idle", 4'd0, 50);

    // Single-step mode.
    sw_sel = 1'b1; sw_bit_inicial = 8'h3C; ack_delay = 60;
    press_btn();
    wait_state("ss_wait", 4'd2, 50);
    steps0 = n_steps;
    cycles(30);
    check("ss_no_auto",  32'(n_steps - steps0),   32'd0);
    check("ss_count0",   32'(display_instancias), 32'd0);
    press_btn();
    check("ss_in_step",  32'(actual_state),       32'd3);
    press_btn();
    wait_state("ss_back_wait", 4'd2, 200);
    check("ss_count1",   32'(display_instancias), 32'd1);
    check("ss_one_step", 32'(n_steps - steps0),   32'd1);
    cycles(10);
    check("ss_not_queued", 32'(actual_state),     32'd2);
    press_btn();
    wait_state("ss_wait2", 4'd2, 200);
    check("ss_count2",   32'(display_instancias), 32'd2);

    // Reset in the middle of STEP.
    ack_en = 1'b0;
    press_btn();
    wait_state("rst_in_step", 4'd3, 50);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_step_req", 32'(step_req),           32'd0);
    check("async_state",    32'(actual_state),       32'd0);
    check("async_count",    32'(display_instancias), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    force_ack = 1'b1;
    cycles(2);
    force_ack = 1'b0;
    cycles(5);
    check("no_resume_state", 32'(actual_state), 32'd0);
    check("no_resume_req",   32'(step_req),     32'd0);

    // Pause and resume.
    ack_en = 1'b1; ack_delay = 2; sw_bit_inicial = 8'h81;
    press_btn();
    wait_state("pause_wait", 4'd2, 50);
    btn_inicio = 1'b1;
    cycles(LAT - 2);
    sw_sel = 1'b0;
    cycles(HOLD - (LAT - 2));
    btn_inicio = 1'b0;
    wait_state("pause_enter", 4'd4, 60);
    check("pause_count0", 32'(display_instancias), 32'd0);
    cycles(50);
    check("pause_frozen", 32'(display_instancias), 32'd0);
    check("pause_state",  32'(actual_state),       32'd4);
    @(negedge clk);
    btn_inicio = 1'b1;
    cycles(HOLD);
    btn_inicio = 1'b0;
    wait_state("resume_wait", 4'd2, 60);
    n = 0;
    while (actual_state == 4'd2 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("wait_to_step",  32'(n),            32'(TD));
    check("resume_step",   32'(actual_state), 32'd3);
    wait_state("resume_back", 4'd2, 50);
    check("resume_count",  32'(display_instancias), 32'd1);

    // Press coinciding with the terminal tick.
    sw_sel = 1'b1;
    cycles(LAT + 2);
    steps0 = n_steps;
    btn_inicio = 1'b1;
    cycles(LAT - 3);
    sw_sel = 1'b0;
    cycles(HOLD);
    btn_inicio = 1'b0;
    wait_state("coincide_pause", 4'd4, 60);
    check("coincide_no_step", 32'(n_steps - steps0),   32'd0);
    check("coincide_count",   32'(display_instancias), 32'd1);
    ack_en = 1'b0;
    force_ack = 1'b1;
    cycles(2);
    force_ack = 1'b0;
    cycles(2);
    check("ack_in_pause", 32'(display_instancias), 32'd1);
    sw_sel = 1'b1;
    press_btn();
    wait_state("spur_wait", 4'd2, 60);
    force_ack = 1'b1;
    cycles(2);
    force_ack = 1'b0;
    cycles(3);
    check("ack_in_wait_count", 32'(display_instancias), 32'd1);
    check("ack_in_wait_state", 32'(actual_state),       32'd2);

`ifdef AUTOMATON_BTN_DEBOUNCE_EN
    // Debounce: a short glitch is rejected and a long pulse is accepted once.
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    loads0 = n_loads;
    btn_inicio = 1'b1;
    cycles(5);
    btn_inicio = 1'b0;
    cycles(40);
    check("glitch_ignored", 32'(actual_state), 32'd0);
    btn_inicio = 1'b1;
    cycles(20);
    btn_inicio = 1'b0;
    cycles(40);
    check("pulse_one_press", 32'(actual_state),     32'd2);
    check("pulse_one_load",  32'(n_loads - loads0), 32'd1);
`endif

    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
